// File: rtl/winaddr_pkg.sv
// Shared types and helpers for the window address generator.
// The quantize() helper serves both the truncating build and the
// WINADDR_ROUND_EN (round-to-nearest, saturating) build.
package winaddr_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WCOUNT_W = 16;

    // Top db bits of an sw-bit sample; with round_en, add the next bit down
    // and clamp so a round-up out of the top code sticks at the max address.
    function automatic logic [31:0] quantize(input logic [31:0] sample,
                                             input int          sw,
                                             input int          db,
                                             input bit          round_en);
        logic [31:0] topq;
        logic [31:0] maxq;
        maxq = (32'd1 << db) - 32'd1;
        topq = (sample >> (sw - db)) & maxq;
        if (round_en && (sw > db)) begin
            topq = topq + ((sample >> (sw - db - 1)) & 32'd1);
            if (topq > maxq) topq = maxq;
        end
        return topq;
    endfunction

endpackage

// File: rtl/sample_quantizer.sv
// Combinational raw sample -> table address mapping.
// Build option: WINADDR_ROUND_EN selects round-to-nearest with saturation;
// otherwise the address is the plain truncated top bits of the sample.
module sample_quantizer
    import winaddr_pkg::*;
#(
    parameter int SAMPLEWIDTH = 8,
    parameter int DEPTHBITS   = 3
) (
    input  logic [SAMPLEWIDTH-1:0] s_data,
    output logic [DEPTHBITS-1:0]   q
);

    // Map the incoming sample to its address, rounding only in the rounded build.
    always_comb begin
`ifdef WINADDR_ROUND_EN
        q = DEPTHBITS'(quantize(32'(s_data), SAMPLEWIDTH, DEPTHBITS, 1'b1));
`else
        q = DEPTHBITS'(quantize(32'(s_data), SAMPLEWIDTH, DEPTHBITS, 1'b0));
`endif
    end

endmodule

// File: rtl/window_addr_gen.sv
// Sliding window of quantized sample addresses feeding the 16-port lookup RAM.
// Tap 0 is the newest sample. A window is offered once TAPS samples are in,
// then every STRIDE accepts. The window is frozen while an offer is pending.
// Build option: WINADDR_ROUND_EN (see sample_quantizer) changes quantization only.
module window_addr_gen
    import winaddr_pkg::*;
#(
    parameter int SAMPLEWIDTH = 8,
    parameter int DEPTHBITS   = 3,
    parameter int TAPS        = 16,
    parameter int STRIDE      = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SAMPLEWIDTH-1:0]    s_data,
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic [TAPS*DEPTHBITS-1:0] w_addr,
    output logic [WCOUNT_W-1:0]       w_count
);

    localparam int CW = $clog2(TAPS + 1);

    state_t                          state_q, state_d;
    logic [CW-1:0]                   fill_q, fill_d;
    logic [CW-1:0]                   stride_q, stride_d;
    logic                            emit, w_valid_d;
    logic                            accept, take;
    logic [TAPS-1:0][DEPTHBITS-1:0]  win_q;
    logic [DEPTHBITS-1:0]            q;

    sample_quantizer #(
        .SAMPLEWIDTH (SAMPLEWIDTH),
        .DEPTHBITS   (DEPTHBITS)
    ) u_quant (
        .s_data (s_data),
        .q      (q)
    );

    // A pending window blocks new samples so w_addr cannot move under the consumer.
    assign s_ready = !flush && !(w_valid && !w_ready);
    assign accept  = s_valid && s_ready;
    assign take    = w_valid && w_ready;
    assign w_addr  = win_q;

    // Next state: fill counting, stride counting and window emission.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        stride_d = stride_q;
        emit     = 1'b0;
        if (flush) begin
            state_d  = FILL;
            fill_d   = '0;
            stride_d = '0;
        end else if (accept) begin
            case (state_q)
                FILL: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == CW'(TAPS - 1)) begin
                        emit     = 1'b1;
                        stride_d = '0;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (stride_q == CW'(STRIDE - 1)) begin
                        stride_d = '0;
                        emit     = 1'b1;
                    end else begin
                        stride_d = stride_q + 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end
        // A same-cycle emit wins over the hand-off clear: back-to-back windows.
        if (flush)      w_valid_d = 1'b0;
        else if (emit)  w_valid_d = 1'b1;
        else if (take)  w_valid_d = 1'b0;
        else            w_valid_d = w_valid;
    end

    // FSM, counters and window-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            fill_q   <= '0;
            stride_q <= '0;
            w_valid  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            stride_q <= stride_d;
            w_valid  <= w_valid_d;
        end
    end

    // Shift the newest address into tap 0 on every accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      win_q <= '0;
        else if (flush)  win_q <= '0;
        else if (accept) win_q <= {win_q[TAPS-2:0], q};
    end

    // Count completed hand-offs; wraps naturally and survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    w_count <= '0;
        else if (take) w_count <= w_count + 1'b1;
    end

endmodule

// File: doc/window_addr_gen.md
Name: window_addr_gen

Overview:
- Upstream feeder for the 16-port read-only lookup RAM.
- Accepts a stream of raw time-series samples over a valid/ready handshake and quantizes each sample to a DEPTHBITS-wide table address.
- Keeps a sliding window of the last TAPS addresses.
- Presents the window as a flat address bus, one slice per lookup port, with its own valid/ready handshake. A window is emitted every STRIDE samples once the window is full.

Parameters:
- SAMPLEWIDTH, 8: raw sample width, unsigned.
- DEPTHBITS, 3: address width per tap. Must match the lookup RAM.
- TAPS, 16: window length, i.e. the number of lookup ports.
- STRIDE, 1: number of accepted samples between emitted windows after the first full window. Legal range 1..TAPS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of window and counters.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready.
- s_data  in  SAMPLEWIDTH  raw sample.
- w_valid  out  1  window valid.
- w_ready  in  1  window consumer ready.
- w_addr  out  TAPS*DEPTHBITS  tap k at [k*DEPTHBITS +: DEPTHBITS]. Tap 0 is the newest sample; tap k drives lookup port in<k>.
- w_count  out  16  number of windows handed off; wraps at 2^16.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: w_valid=0, w_addr=0, w_count=0, fill_cnt=0, stride_cnt=0, state=FILL.
- s_ready = !flush && !(w_valid && !w_ready). Accept means s_valid && s_ready.
- Quantize: q = s_data[SAMPLEWIDTH-1 -: DEPTHBITS], i.e. truncation to the top bits.
- On accept, the window shifts: tap k takes tap k-1 for k = TAPS-1 down to 1, and tap 0 takes q.
- fill_cnt counts accepts and saturates at TAPS. stride_cnt runs 0..STRIDE-1.
- State FILL:
  - Each accept increments fill_cnt.
  - On the accept that brings fill_cnt to TAPS: w_valid=1 on the next cycle, stride_cnt=0, go to RUN.
- State RUN:
  - Each accept increments stride_cnt.
  - On the accept where stride_cnt == STRIDE-1: stride_cnt=0 and w_valid=1 on the next cycle.
  - With STRIDE=1, every accept produces a window.
- Handshake: w_valid=1 and w_addr hold stable until w_ready.
  - On w_valid && w_ready: w_count+1, and w_valid clears unless the same cycle's accept sets it again.
- Simultaneous hand-off and accept:
  - Both occur in one cycle; the new window appears on the next cycle.
  - Result is back-to-back windows at full rate, with no bubble for STRIDE=1.
- Latency: one cycle from the accepting edge to w_valid/w_addr reflecting that sample.
- Stall: while w_valid && !w_ready, s_ready=0, so the window cannot change under the consumer.
- flush (synchronous; beats an accept in the same cycle):
  - Clears window, fill_cnt, stride_cnt and w_valid; state goes to FILL.
  - w_count is kept.
  - A pending un-taken window is discarded.
- Asynchronous reset mid-window: all state returns to reset values immediately. No partial window is ever emitted.
- w_count wraps from 0xFFFF to 0x0000.

Optional Feature:
- Macro WINADDR_ROUND_EN.
- Defined: round-to-nearest quantization with saturation. q = top DEPTHBITS + bit [SAMPLEWIDTH-DEPTHBITS-1], clamped to 2^DEPTHBITS-1.
- Undefined: plain truncation as above.
- Timing and handshake are identical in both builds.

Decomposition:
- Package winaddr_pkg: state enum (FILL, RUN), the width constant for w_count (16), and a quantize function used by both build variants.
- One natural sub-module: sample_quantizer, the combinational s_data -> q path, which carries the WINADDR_ROUND_EN variant.
- Shift window, counters, FSM and handshake stay in the top module.

Test Plan:
- Reset then stream 0x00,0x20,...,0xE0 repeating (addr 0..7), w_ready=1, STRIDE=1:
  - no w_valid for the first 15 accepts;
  - after the 16th, w_valid=1 with tap0=7 and tap15=0;
  - thereafter one window per sample; w_count increments each cycle.
- STRIDE=4, continuous samples after fill: windows at accepts 16, 20, 24, and w_valid low in between.
- Hold w_ready=0 for 5 cycles with a window pending:
  - s_ready=0 and w_addr stable;
  - on release, the window is taken, w_count+1, and s_ready returns on the same cycle.
- Assert flush on the same cycle as s_valid with 10 samples buffered:
  - sample dropped (s_ready=0);
  - the next window appears only after 16 fresh accepts;
  - w_count unchanged.
- Deassert rst_n mid-stream: w_valid=0 and w_addr=0 immediately, without waiting for a clock edge.
- WINADDR_ROUND_EN defined, 8/3 widths: 0x50 -> 3, 0xF5 -> 7 (saturates), 0x0F -> 0. Undefined: 0x50 -> 2, 0xF5 -> 7.
